// File: rtl/sw_array_feeder_if.sv
// Boundary bus between the Smith-Waterman feeder and its systolic PE chain:
// PE0 head inputs plus the per-PE MAX/init taps fed back to the feeder.
interface sw_array_feeder_if #(
  parameter int unsigned NPE = 8,
  parameter int unsigned DW  = 12
);
  logic                pe_changeS;
  logic [2*NPE-1:0]    pe_S;
  logic [1:0]          pe_T;
  logic                pe_init;
  logic [DW-1:0]       pe_V;
  logic [DW-1:0]       pe_F;
  logic [DW-1:0]       pe_MAX;
  logic [DW*NPE-1:0]   tap_max;
  logic [NPE-1:0]      tap_init;

  modport master (
    output pe_changeS, pe_S, pe_T, pe_init, pe_V, pe_F, pe_MAX,
    input  tap_max, tap_init
  );

  modport slave (
    input  pe_changeS, pe_S, pe_T, pe_init, pe_V, pe_F, pe_MAX,
    output tap_max, tap_init
  );
endinterface

// File: rtl/sw_array_feeder.sv
// Head-and-tail controller for the Smith-Waterman PE chain: loads the query,
// streams the target into PE0, and captures the final score from the tap of the last used PE.
module sw_array_feeder #(
  parameter int unsigned   NPE     = 8,
  parameter int unsigned   TLW     = 10,
  parameter int unsigned   DW      = 12,
  parameter logic [DW-1:0] NEG_INF = 12'h900
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [2*NPE-1:0]           s_seq,
  input  logic [$clog2(NPE+1)-1:0]   s_len,
  input  logic [TLW-1:0]             t_len,
  input  logic                       t_valid,
  input  logic [1:0]                 t_data,
  output logic                       t_ready,
  sw_array_feeder_if.master          pe,
  output logic                       busy,
  output logic                       res_valid,
  output logic [DW-1:0]              res_score,
  output logic                       res_err,
  input  logic                       res_ready
);

  localparam int unsigned SLW  = $clog2(NPE + 1);
  localparam int unsigned SELW = (NPE > 1) ? $clog2(NPE) : 1;
  localparam int unsigned CW   = TLW + 1;
  localparam int unsigned WDW  = TLW + 2;
  localparam logic [SLW-1:0] NPE_L = SLW'(NPE);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_STREAM = 3'd1;
  localparam logic [2:0] S_FLUSH  = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_RESULT = 3'd4;

  logic [2:0]        state_q,      state_d;
  logic [2*NPE-1:0]  pe_s_q,       pe_s_d;
  logic [1:0]        pe_t_q,       pe_t_d;
  logic              pe_init_q,    pe_init_d;
  logic              pe_changes_q, pe_changes_d;
  logic [SELW-1:0]   sel_q,        sel_d;
  logic [TLW-1:0]    t_len_q,      t_len_d;
  logic [CW-1:0]     cnt_q,        cnt_d;
  logic [WDW-1:0]    wd_q,         wd_d;
  logic [DW-1:0]     res_score_q,  res_score_d;
  logic              res_err_q,    res_err_d;

  logic [DW-1:0]     tap_lane [NPE];
  logic [DW-1:0]     tap_max_sel;
  logic              tap_init_sel;
  logic              capture;
  logic [CW-1:0]     cnt_inc;
  logic [WDW-1:0]    wd_last;

  always_comb begin
    for (int unsigned k = 0; k < NPE; k++) begin
      tap_lane[k] = pe.tap_max[k*DW +: DW];
    end
  end

  assign tap_max_sel  = tap_lane[sel_q];
  assign tap_init_sel = pe.tap_init[sel_q];
  assign cnt_inc      = cnt_q + 1'b1;
  // Capture on the (t_len+1)-th init-high tap cycle: cnt_q already holds t_len earlier ones.
  assign capture      = tap_init_sel && (cnt_q == CW'(t_len_q));
  assign wd_last      = WDW'(t_len_q) + WDW'(NPE + 3);

  always_comb begin
    state_d      = state_q;
    pe_s_d       = pe_s_q;
    pe_t_d       = pe_t_q;
    pe_init_d    = pe_init_q;
    pe_changes_d = pe_changes_q;
    sel_d        = sel_q;
    t_len_d      = t_len_q;
    cnt_d        = cnt_q;
    wd_d         = wd_q;
    res_score_d  = res_score_q;
    res_err_d    = res_err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pe_s_d  = s_seq;
          t_len_d = t_len;
          sel_d   = SELW'(s_len - 1'b1);
          cnt_d   = '0;
          if (s_len == '0 || s_len > NPE_L || t_len == '0) begin
            state_d     = S_RESULT;
            res_err_d   = 1'b1;
            res_score_d = '0;
          end else begin
            state_d = S_STREAM;
          end
        end
      end
      S_STREAM: begin
        if (t_valid) begin
          pe_t_d       = t_data;
          pe_init_d    = 1'b1;
          pe_changes_d = (cnt_q == '0);
          cnt_d        = cnt_inc;
          if (cnt_inc == CW'(t_len_q)) begin
            state_d = S_FLUSH;
            cnt_d   = '0;
          end
        end else begin
          // The chain cannot stall, so a gap in the target stream aborts the job.
          pe_init_d    = 1'b0;
          pe_changes_d = 1'b0;
          res_err_d    = 1'b1;
          res_score_d  = '0;
          state_d      = S_RESULT;
        end
      end
      S_FLUSH: begin
        pe_t_d       = 2'b00;
        pe_init_d    = 1'b1;
        pe_changes_d = 1'b0;
        cnt_d        = '0;
        wd_d         = '0;
        state_d      = S_DRAIN;
      end
      S_DRAIN: begin
        pe_init_d = 1'b0;
        if (tap_init_sel) begin
          cnt_d = cnt_inc;
        end
        if (capture) begin
          res_score_d = tap_max_sel;
          res_err_d   = 1'b0;
          state_d     = S_RESULT;
        end else if (wd_q == wd_last) begin
          res_score_d = '0;
          res_err_d   = 1'b1;
          state_d     = S_RESULT;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_RESULT: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pe_s_q       <= '0;
      pe_t_q       <= '0;
      pe_init_q    <= 1'b0;
      pe_changes_q <= 1'b0;
      sel_q        <= '0;
      t_len_q      <= '0;
      cnt_q        <= '0;
      wd_q         <= '0;
      res_score_q  <= '0;
      res_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pe_s_q       <= pe_s_d;
      pe_t_q       <= pe_t_d;
      pe_init_q    <= pe_init_d;
      pe_changes_q <= pe_changes_d;
      sel_q        <= sel_d;
      t_len_q      <= t_len_d;
      cnt_q        <= cnt_d;
      wd_q         <= wd_d;
      res_score_q  <= res_score_d;
      res_err_q    <= res_err_d;
    end
  end

  assign pe.pe_changeS = pe_changes_q;
  assign pe.pe_S       = pe_s_q;
  assign pe.pe_T       = pe_t_q;
  assign pe.pe_init    = pe_init_q;
  assign pe.pe_V       = '0;
  assign pe.pe_F       = NEG_INF;
  assign pe.pe_MAX     = '0;

  assign t_ready   = (state_q == S_STREAM);
  assign busy      = (state_q != S_IDLE);
  assign res_valid = (state_q == S_RESULT);
  assign res_score = res_score_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_sw_array_feeder.sv
// Directed bench for sw_array_feeder; the bench plays the PE chain by driving the taps.
module tb_sw_array_feeder;
  localparam int unsigned NPE = 8;
  localparam int unsigned TLW = 10;
  localparam int unsigned DW  = 12;
  localparam int unsigned SLW = $clog2(NPE + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [2*NPE-1:0]  s_seq;
  logic [SLW-1:0]    s_len;
  logic [TLW-1:0]    t_len;
  logic              t_valid;
  logic [1:0]        t_data;
  logic              t_ready;
  logic              busy;
  logic              res_valid;
  logic [DW-1:0]     res_score;
  logic              res_err;
  logic              res_ready;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sw_array_feeder_if #(.NPE(NPE), .DW(DW)) pe_bus ();

  sw_array_feeder #(
    .NPE(NPE), .TLW(TLW), .DW(DW), .NEG_INF(12'h900)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .s_seq(s_seq), .s_len(s_len),
    .t_len(t_len), .t_valid(t_valid), .t_data(t_data), .t_ready(t_ready),
    .pe(pe_bus.master), .busy(busy), .res_valid(res_valid),
    .res_score(res_score), .res_err(res_err), .res_ready(res_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_taps;
    pe_bus.tap_init = '0;
    pe_bus.tap_max  = {NPE{12'h555}};
  endtask

  task automatic accept;
    res_ready = 1'b1;
    tick;
    res_ready = 1'b0;
    check("accept_idle", busy, 0);
  endtask

  // Full job with the tap of PE sl-1 pulsing t_len+1 cycles; the last tap value is fin.
  task automatic run_job(input logic [2*NPE-1:0] seq, input int sl, input int tl,
                         input logic [DW-1:0] fin, input string tag);
    start = 1'b1; s_seq = seq; s_len = SLW'(sl); t_len = TLW'(tl);
    tick;
    start = 1'b0;
    for (int i = 0; i < tl; i++) begin
      t_valid = 1'b1; t_data = 2'(i);
      tick;
    end
    t_valid = 1'b0;
    tick;
    for (int j = 0; j <= tl; j++) begin
      pe_bus.tap_init[sl-1] = 1'b1;
      pe_bus.tap_max[(sl-1)*DW +: DW] = (j == tl) ? fin : DW'(j);
      tick;
    end
    clear_taps;
    check({tag, "_valid"}, res_valid, 1);
    check({tag, "_score"}, res_score, fin);
    check({tag, "_err"}, res_err, 0);
    check({tag, "_pe_S"}, pe_bus.pe_S, seq);
  endtask

  initial begin
    logic [1:0]    syms [5];
    logic [DW-1:0] taps [6];
    int            n;

    syms = '{2'd2, 2'd1, 2'd3, 2'd0, 2'd2};
    taps = '{12'd0, 12'd2, 12'd4, 12'd9, 12'd7, 12'd11};

    rst = 1'b1; start = 1'b0; s_seq = '0; s_len = '0; t_len = '0;
    t_valid = 1'b0; t_data = '0; res_ready = 1'b0;
    clear_taps;
    tick; tick;
    check("rst_busy", busy, 0);
    check("rst_pe_F", pe_bus.pe_F, 12'h900);
    check("rst_res_valid", res_valid, 0);
    rst = 1'b0;

    // Reset in the middle of STREAM
    start = 1'b1; s_seq = 16'h00E4; s_len = 4; t_len = 5;
    tick;
    start = 1'b0; t_valid = 1'b1; t_data = 2'd3;
    tick; tick;
    check("mid_init", pe_bus.pe_init, 1);
    rst = 1'b1;
    repeat (3) tick;
    rst = 1'b0; t_valid = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_init", pe_bus.pe_init, 0);
    check("mid_rst_pe_F", pe_bus.pe_F, 12'h900);
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_pe_S", pe_bus.pe_S, 0);
    check("mid_rst_t_ready", t_ready, 0);

    // Nominal job: ACGT, s_len=4, t_len=5
    start = 1'b1; s_seq = 16'h00E4; s_len = 4; t_len = 5;
    t_valid = 1'b1; t_data = syms[0];
    tick;
    start = 1'b0;
    check("nom_busy", busy, 1);
    for (int i = 0; i < 5; i++) begin
      check("nom_t_ready", t_ready, 1);
      t_data = syms[i];
      tick;
      check("nom_pe_T", pe_bus.pe_T, syms[i]);
      check("nom_changeS", pe_bus.pe_changeS, (i == 0) ? 1 : 0);
      check("nom_init", pe_bus.pe_init, 1);
      check("nom_pe_S", pe_bus.pe_S, 16'h00E4);
    end
    t_valid = 1'b0;
    check("nom_flush_t_ready", t_ready, 0);
    tick;
    check("nom_flush_init", pe_bus.pe_init, 1);
    check("nom_flush_T", pe_bus.pe_T, 0);
    check("nom_flush_changeS", pe_bus.pe_changeS, 0);
    for (int j = 0; j < 6; j++) begin
      pe_bus.tap_init[3] = 1'b1;
      pe_bus.tap_max[3*DW +: DW] = taps[j];
      tick;
      check("nom_drain_init", pe_bus.pe_init, 0);
      check("nom_drain_t_ready", t_ready, 0);
      if (j < 5) check("nom_no_early_valid", res_valid, 0);
    end
    clear_taps;
    check("nom_valid", res_valid, 1);
    check("nom_score", res_score, 12'd11);
    check("nom_err", res_err, 0);
    check("nom_pe_S_end", pe_bus.pe_S, 16'h00E4);
    accept;

    // Underflow on the third symbol
    start = 1'b1; s_seq = 16'h0024; s_len = 3; t_len = 6;
    tick;
    start = 1'b0; t_valid = 1'b1; t_data = 2'd1;
    tick; tick;
    check("uf_init_hi", pe_bus.pe_init, 1);
    t_valid = 1'b0;
    tick;
    check("uf_init_lo", pe_bus.pe_init, 0);
    check("uf_valid", res_valid, 1);
    check("uf_err", res_err, 1);
    check("uf_score", res_score, 0);
    accept;

    // Illegal lengths go straight to an error result
    for (int k = 0; k < 3; k++) begin
      start = 1'b1; s_seq = 16'h1234;
      s_len = (k == 0) ? SLW'(0) : (k == 1) ? SLW'(NPE + 1) : SLW'(4);
      t_len = (k == 2) ? TLW'(0) : TLW'(5);
      check("bad_t_ready_idle", t_ready, 0);
      tick;
      start = 1'b0;
      check("bad_t_ready", t_ready, 0);
      check("bad_valid", res_valid, 1);
      check("bad_err", res_err, 1);
      check("bad_score", res_score, 0);
      accept;
    end

    // Result held under backpressure, start ignored, then back-to-back job
    run_job(16'h1B2D, 5, 4, 12'h1AB, "bp");
    for (int k = 0; k < 10; k++) begin
      start = (k == 3); s_seq = 16'hAAAA; s_len = '0;
      tick;
      check("bp_hold_valid", res_valid, 1);
      check("bp_hold_score", res_score, 12'h1AB);
      check("bp_hold_err", res_err, 0);
    end
    start = 1'b0;
    check("bp_pe_S", pe_bus.pe_S, 16'h1B2D);
    accept;
    run_job(16'hFFFF, 8, 3, 12'h7FF, "b2b");
    accept;

    // Watchdog: tap never pulses
    start = 1'b1; s_seq = 16'h0006; s_len = 2; t_len = 5;
    tick;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      t_valid = 1'b1; t_data = 2'(i);
      tick;
    end
    t_valid = 1'b0;
    tick;
    n = 0;
    while (!res_valid && n < 60) begin
      tick;
      n++;
    end
    check("wd_cycles", n, NPE + 5 + 4);
    check("wd_err", res_err, 1);
    check("wd_score", res_score, 0);
    accept;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sw_array_feeder.md
Name: sw_array_feeder

Overview:
- Head-and-tail controller for the Smith-Waterman systolic PE chain.
- Accepts one query S (up to NPE symbols, parallel) and one streamed target T.
- Drives PE0's boundary inputs (changeS, S bus, T, init, V/F/MAX boundary) and watches the per-PE MAX/init taps.
- Returns the final local-alignment score over a valid/ready result port.

Parameters:
- NPE, 8, number of PEs in the chain; max supported s_len.
- TLW, 10, width of t_len; max target length 2^TLW-1.
- DW, 12, score width; matches the PE datapath.
- NEG_INF, 12'h900, boundary F value (approximately -INF).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin job; ignored while busy
- s_seq  in  2*NPE  query symbols; PE k uses bits [2k+1:2k]; sampled on accepted start
- s_len  in  $clog2(NPE+1)  query length; sampled on start
- t_len  in  TLW  target length; sampled on start
- t_valid  in  1  target symbol valid
- t_data  in  2  target symbol
- t_ready  out  1  feeder consumes t_data this cycle
- pe_changeS  out  1  to PE0 changeS_in
- pe_S  out  2*NPE  per-PE S_in bus, held stable for the whole job
- pe_T  out  2  to PE0 T_in
- pe_init  out  1  to PE0 init_in
- pe_V  out  DW  to PE0 V_in; constant 0
- pe_F  out  DW  to PE0 F_in; constant NEG_INF
- pe_MAX  out  DW  to PE0 MAX_in; constant 0
- tap_max  in  DW*NPE  MAX_out of every PE
- tap_init  in  NPE  init_out of every PE
- busy  out  1  state != IDLE
- res_valid  out  1  result available
- res_score  out  DW  final score
- res_err  out  1  job aborted
- res_ready  in  1  result accepted

Behaviour:
- Reset values: all outputs 0, except pe_F = NEG_INF. pe_S is cleared. State = IDLE. Reset mid-job abandons the job with no result.
- State machine: IDLE -> STREAM -> FLUSH -> DRAIN -> RESULT -> IDLE.
- IDLE:
  - On start, latch s_seq into pe_S, and latch s_len/t_len. Set sel = s_len-1, cnt = 0.
  - If s_len==0, s_len>NPE or t_len==0: go to RESULT with err=1, score=0.
  - Otherwise go to STREAM.
- STREAM:
  - t_ready = 1 combinationally.
  - On t_valid: register pe_T <= t_data and pe_init <= 1. pe_changeS <= 1 only for the first symbol, else 0. Increment the symbol count.
  - After t_len symbols, go to FLUSH.
  - If t_valid=0 in any STREAM cycle (underflow): pe_init <= 0, err=1, score=0, go to RESULT. The chain cannot stall.
- FLUSH, one cycle:
  - pe_T <= 0, pe_init <= 1, pe_changeS <= 0.
  - Net effect: pe_init is high for exactly t_len+1 consecutive cycles.
  - Go to DRAIN with pe_init <= 0.
- DRAIN:
  - Count cycles where tap_init[sel]=1.
  - On the (t_len+1)-th such cycle, capture res_score <= tap_max[sel] and go to RESULT. That is the last init-high cycle of the selected PE; it covers columns 0..t_len-1 and excludes the flush column.
  - Watchdog: if capture has not occurred within NPE+t_len+4 cycles of entering DRAIN, err=1, score=0, go to RESULT.
- RESULT:
  - res_valid = 1; res_score and res_err are held stable.
  - Go to IDLE on res_valid & res_ready. start is ignored until then.
  - A new start is accepted the cycle after return to IDLE.
- Latency: the first symbol's handshake cycle c puts it on PE0's inputs at c+1.
- pe_S changes only on an accepted start, never mid-job.
- Unused PEs beyond s_len are not tapped; their values are don't-care.

Test Plan:
- Reset held 3 cycles mid-STREAM -> next cycle: busy=0, pe_init=0, pe_F=12'h900, res_valid=0. A fresh job afterwards completes normally.
- Nominal job (s_seq=ACGT packed, s_len=4, t_len=5, t_valid always 1) -> t_ready high 5 cycles. pe_init high 6 consecutive cycles. pe_changeS is a single pulse aligned with the first pe_T. pe_S is constant.
- Same job, bench drives tap_init[3] as a 6-cycle pulse with tap_max[3]=0,2,4,9,7,11 -> res_score=11 (captured on the 6th cycle), res_err=0.
- t_valid dropped on the 3rd symbol -> pe_init falls the next cycle, res_valid with res_err=1 and res_score=0, no DRAIN.
- s_len=0 or s_len=NPE+1 at start -> RESULT the next cycle with res_err=1, t_ready never asserted.
- res_ready held low 10 cycles with start pulsed meanwhile -> result stable, start ignored. After acceptance, a second job runs back-to-back correctly.
- Tap never pulses -> watchdog fires at NPE+t_len+4 cycles, res_err=1.
